// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and state encoding for the front-end pipeline sequencer.
package cpu_ctrl_pkg;

   localparam int unsigned OpcW = 7;
   localparam int unsigned RegW = 3;

   localparam logic [OpcW-1:0] OpcHlt   = 7'b1100001;
   localparam logic [OpcW-1:0] OpcIadd  = 7'b0100000;
   // Immediate-class instructions are identified by opcode bits [6:5] alone.
   localparam logic [1:0]      ImmClass = 2'b01;

   typedef enum logic [1:0] {
      StRun  = 2'b00,
      StImm  = 2'b01,
      StHalt = 2'b10
   } seq_state_e;

   function automatic logic is_imm_class(input logic [OpcW-1:0] opc);
      return opc[6:5] == ImmClass;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: decode-stage sources against a load's destination in EX.
module hazard_detect
   import cpu_ctrl_pkg::*;
(
   input  logic            id_valid_i,
   input  logic [RegW-1:0] id_rs1_i,
   input  logic [RegW-1:0] id_rs2_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic            ex_load_i,
   input  logic [RegW-1:0] ex_rd_i,
   output logic            load_use_o
);

   logic rs1_hit, rs2_hit;

   assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
   assign load_use_o = id_valid_i && ex_load_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Front-end sequencer: PC/IF-ID/ID-EX enables, load-use stalls, two-word immediates,
// halt freeze and a saturating stall-cycle counter.
module pipe_seq_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CntW = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            id_valid_i,
   input  logic [OpcW-1:0] id_opcode_i,
   input  logic [RegW-1:0] id_rs1_i,
   input  logic [RegW-1:0] id_rs2_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic            ex_load_i,
   input  logic [RegW-1:0] ex_rd_i,
   input  logic            mem_busy_i,
   input  logic            stat_clr_i,
   output logic            pc_en_o,
   output logic            ifid_en_o,
   output logic            ifid_flush_o,
   output logic            idex_bubble_o,
   output logic            imm_hold_o,
   output logic            imm_phase_o,
   output logic            halted_o,
   output logic [CntW-1:0] stall_cnt_o
);

   seq_state_e      state_q, state_d;
   logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
   logic            load_use;
   logic            pc_en, ifid_en, ifid_flush, idex_bubble, imm_hold, imm_phase, halted;

   hazard_detect u_hazard_detect (
      .id_valid_i    (id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_used_i (id_rs2_used_i),
      .ex_load_i     (ex_load_i),
      .ex_rd_i       (ex_rd_i),
      .load_use_o    (load_use)
   );

   always_comb begin
      state_d     = state_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      imm_hold    = 1'b0;
      imm_phase   = 1'b0;
      halted      = 1'b0;
      unique case (state_q)
         StRun: begin
            if (mem_busy_i) begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
            end else if (id_valid_i && (id_opcode_i == OpcHlt)) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
               state_d    = StHalt;
            end else if (load_use) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
            end else if (id_valid_i && is_imm_class(id_opcode_i)) begin
               imm_hold    = 1'b1;
               idex_bubble = 1'b1;
               state_d     = StImm;
            end
         end
         StImm: begin
            // IF/ID now holds the immediate word; its opcode bits are never decoded.
            if (mem_busy_i) begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
            end else begin
               imm_phase = 1'b1;
               state_d   = StRun;
            end
         end
         StHalt: begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b1;
         end
         default: state_d = StRun;
      endcase
   end

   // Outputs are Mealy, so they must be forced quiet while reset is held.
   always_comb begin
      pc_en_o       = rst_ni & pc_en;
      ifid_en_o     = rst_ni & ifid_en;
      ifid_flush_o  = rst_ni & ifid_flush;
      idex_bubble_o = rst_ni & idex_bubble;
      imm_hold_o    = rst_ni & imm_hold;
      imm_phase_o   = rst_ni & imm_phase;
      halted_o      = rst_ni & halted;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stat_clr_i) begin
         stall_cnt_d = '0;
      end else if ((state_q != StHalt) && (idex_bubble || mem_busy_i) &&
                   (stall_cnt_q != {CntW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StRun;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl; a narrow-counter instance covers saturation.
module tb_pipe_seq_ctrl;
   import cpu_ctrl_pkg::*;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            id_valid_i;
   logic [OpcW-1:0] id_opcode_i;
   logic [RegW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
   logic            id_rs1_used_i, id_rs2_used_i, ex_load_i, mem_busy_i, stat_clr_i;
   logic            pc_en, ifid_en, ifid_flush, idex_bubble, imm_hold, imm_phase, halted;
   logic            s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble;
   logic            s_imm_hold, s_imm_phase, s_halted;
   logic [15:0]     stall_cnt;
   logic [3:0]      s_stall_cnt;
   logic [6:0]      outs;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [OpcW-1:0] OpcAdd = 7'b0000001;
   // {pc_en, ifid_en, ifid_flush, idex_bubble, imm_hold, imm_phase, halted}
   localparam logic [6:0] ORun   = 7'b1100000;
   localparam logic [6:0] OZero  = 7'b0000000;
   localparam logic [6:0] OLdUse = 7'b0001000;
   localparam logic [6:0] OImmN  = 7'b1101100;
   localparam logic [6:0] OImmP  = 7'b1100010;
   localparam logic [6:0] OHlt   = 7'b0110000;
   localparam logic [6:0] OHalt  = 7'b0011001;

   always #5 clk_i = ~clk_i;

   assign outs = {pc_en, ifid_en, ifid_flush, idex_bubble, imm_hold, imm_phase, halted};

   pipe_seq_ctrl #(.CntW(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_used_i(id_rs1_used_i),
      .id_rs2_used_i(id_rs2_used_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
      .mem_busy_i(mem_busy_i), .stat_clr_i(stat_clr_i), .pc_en_o(pc_en), .ifid_en_o(ifid_en),
      .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .imm_hold_o(imm_hold),
      .imm_phase_o(imm_phase), .halted_o(halted), .stall_cnt_o(stall_cnt)
   );

   pipe_seq_ctrl #(.CntW(4)) dut_sat (
      .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs1_used_i(id_rs1_used_i),
      .id_rs2_used_i(id_rs2_used_i), .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
      .mem_busy_i(mem_busy_i), .stat_clr_i(stat_clr_i), .pc_en_o(s_pc_en),
      .ifid_en_o(s_ifid_en), .ifid_flush_o(s_ifid_flush), .idex_bubble_o(s_idex_bubble),
      .imm_hold_o(s_imm_hold), .imm_phase_o(s_imm_phase), .halted_o(s_halted),
      .stall_cnt_o(s_stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; checks run 2 units later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [OpcW-1:0] opc, input logic ld,
                        input logic busy, input logic clr);
      id_valid_i  = v;
      id_opcode_i = opc;
      ex_load_i   = ld;
      mem_busy_i  = busy;
      stat_clr_i  = clr;
      #2;
   endtask

   initial begin
      rst_ni        = 1'b0;
      id_rs1_i      = 3'd1;
      id_rs2_i      = 3'd3;
      id_rs1_used_i = 1'b1;
      id_rs2_used_i = 1'b1;
      ex_rd_i       = 3'd3;
      drive(1'b0, OpcAdd, 1'b0, 1'b0, 1'b0);
      #10;
      check_eq("reset_outs", 32'(outs), 32'(OZero));
      check_eq("reset_cnt", 32'(stall_cnt), 0);
      rst_ni = 1'b1;
      tick();

      // ADD stream, no hazard (ex_load low)
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b0);
         check_eq("add_stream", 32'(outs), 32'(ORun));
         tick();
      end
      check_eq("add_cnt", 32'(stall_cnt), 0);

      // load-use on rs2 == ex_rd == 3
      drive(1'b1, OpcAdd, 1'b1, 1'b0, 1'b0);
      check_eq("load_use", 32'(outs), 32'(OLdUse));
      tick();
      drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b0);
      check_eq("after_ld", 32'(outs), 32'(ORun));
      check_eq("ld_cnt", 32'(stall_cnt), 1);
      tick();

      // IADD then immediate word whose opcode bits look like HLT and hit a load
      drive(1'b1, OpcIadd, 1'b0, 1'b0, 1'b0);
      check_eq("iadd_hold", 32'(outs), 32'(OImmN));
      tick();
      drive(1'b1, OpcHlt, 1'b1, 1'b0, 1'b0);
      check_eq("imm_phase", 32'(outs), 32'(OImmP));
      tick();
      drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b0);
      check_eq("post_imm", 32'(outs), 32'(ORun));
      check_eq("imm_cnt", 32'(stall_cnt), 2);
      tick();

      // mem_busy for 3 cycles while in IMM
      drive(1'b1, OpcIadd, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OpcAdd, 1'b0, 1'b1, 1'b0);
         check_eq("imm_busy", 32'(outs), 32'(OZero));
         tick();
      end
      check_eq("busy_cnt", 32'(stall_cnt), 6);
      drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b0);
      check_eq("imm_after_busy", 32'(outs), 32'(OImmP));
      tick();

      // stat_clr alone, then stat_clr against a load-use bubble
      drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("clr_cnt", 32'(stall_cnt), 0);
      drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, OpcAdd, 1'b1, 1'b0, 1'b1);
      tick();
      check_eq("clr_wins", 32'(stall_cnt), 0);

      // id_valid low: hazard and HLT inputs ignored
      drive(1'b0, OpcHlt, 1'b1, 1'b0, 1'b0);
      check_eq("invalid_id", 32'(outs), 32'(ORun));
      tick();

      // reset asserted mid-IMM
      drive(1'b1, OpcIadd, 1'b0, 1'b0, 1'b0);
      tick();
      rst_ni = 1'b0;
      #2;
      check_eq("rst_imm_outs", 32'(outs), 32'(OZero));
      check_eq("rst_imm_cnt", 32'(stall_cnt), 0);
      rst_ni = 1'b1;
      drive(1'b0, OpcAdd, 1'b0, 1'b0, 1'b0);
      check_eq("rst_imm_run", 32'(outs), 32'(ORun));
      tick();

      // HLT freezes until reset
      drive(1'b1, OpcHlt, 1'b0, 1'b0, 1'b0);
      check_eq("hlt_issue", 32'(outs), 32'(OHlt));
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, (i % 2 == 0) ? OpcIadd : OpcAdd, 1'b1, i[0], 1'b0);
         check_eq("halted", 32'(outs), 32'(OHalt));
         tick();
      end
      check_eq("halt_cnt", 32'(stall_cnt), 0);
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      drive(1'b1, OpcAdd, 1'b0, 1'b0, 1'b0);
      check_eq("halt_exit", 32'(outs), 32'(ORun));
      tick();

      // saturation: 20 busy cycles; 4-bit counter pins at 15
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, OpcAdd, 1'b0, 1'b1, 1'b0);
         tick();
      end
      check_eq("cnt20", 32'(stall_cnt), 20);
      check_eq("sat_busy", 32'(s_stall_cnt), 15);
      drive(1'b1, OpcAdd, 1'b1, 1'b0, 1'b0);
      check_eq("sat_bubble_outs", 32'({s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble,
                                        s_imm_hold, s_imm_phase, s_halted}), 32'(OLdUse));
      tick();
      check_eq("cnt21", 32'(stall_cnt), 21);
      check_eq("sat_bubble", 32'(s_stall_cnt), 15);
      drive(1'b1, OpcAdd, 1'b0, 1'b1, 1'b1);
      tick();
      check_eq("sat_clr", 32'(s_stall_cnt), 0);
      check_eq("big_clr", 32'(stall_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
